ppu_vram_arbiter: RTL and testbench

//  Owns the single PPU VRAM port and shares it between the background-rendering fetch engine
//  (NT/AT/BG_Lsb/BG_Msb fetches, one per 8-clk slot) and CPU PPUDATA reads/writes.

---
 rtl/ppu_vram_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_ppu_vram_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_vram_arbiter.sv
// Shares the single PPU VRAM port between background fetches (fixed priority) and a
// one-entry buffered CPU PPUDATA access; each access holds the port for MEM_LAT clocks.
module ppu_vram_arbiter #(
    parameter int AW      = 14,
    parameter int DW      = 8,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rendering_active_i,
    input  logic          rnd_req_i,
    input  logic [AW-1:0] rnd_addr_i,
    output logic          rnd_gnt_o,
    output logic          rnd_rvalid_o,
    output logic [DW-1:0] rnd_rdata_o,
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic          cpu_busy_o,
    output logic          cpu_done_o,
    output logic [DW-1:0] cpu_rdata_o,
    output logic          cpu_overrun_o,
    input  logic          cpu_overrun_clr_i,
    output logic          vram_en_o,
    output logic          vram_we_o,
    output logic [AW-1:0] vram_addr_o,
    output logic [DW-1:0] vram_wdata_o,
    input  logic [DW-1:0] vram_rdata_i
);

    localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e          state_q;
    logic [2:0]      cnt_q;
    logic            owner_cpu_q;
    logic            vram_en_q;
    logic            vram_we_q;
    logic [AW-1:0]   vram_addr_q;
    logic [DW-1:0]   vram_wdata_q;
    logic            rnd_rvalid_q;
    logic [DW-1:0]   rnd_rdata_q;
    logic            cpu_done_q;
    logic [DW-1:0]   cpu_rdata_q;
    logic            busy_q;
    logic            buf_we_q;
    logic [AW-1:0]   buf_addr_q;
    logic [DW-1:0]   buf_wdata_q;
    logic            overrun_q;

    logic            arb_free_s;
    logic            gnt_rnd_s;
    logic            gnt_cpu_s;
    logic            cpu_fin_s;

    // Arbitration: render first; a buffered CPU access only while rendering is inactive
    always_comb begin
        arb_free_s = (state_q != ST_ACCESS);
        gnt_rnd_s  = 1'b0;
        gnt_cpu_s  = 1'b0;
        if (arb_free_s && rnd_req_i) begin
            gnt_rnd_s = 1'b1;
        end else if (arb_free_s && busy_q && !rendering_active_i) begin
            gnt_cpu_s = 1'b1;
        end else begin
            gnt_rnd_s = 1'b0;
            gnt_cpu_s = 1'b0;
        end
        cpu_fin_s = (state_q == ST_ACCESS) && (cnt_q == 3'd0) && owner_cpu_q;
    end

    // Access sequencer: grant, hold the port MEM_LAT clocks, then respond
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            owner_cpu_q  <= 1'b0;
            vram_en_q    <= 1'b0;
            vram_we_q    <= 1'b0;
            vram_addr_q  <= {AW{1'b0}};
            vram_wdata_q <= {DW{1'b0}};
            rnd_rvalid_q <= 1'b0;
            rnd_rdata_q  <= {DW{1'b0}};
            cpu_done_q   <= 1'b0;
            cpu_rdata_q  <= {DW{1'b0}};
        end else begin
            rnd_rvalid_q <= 1'b0;
            cpu_done_q   <= 1'b0;
            case (state_q)
                ST_IDLE, ST_RESP: begin
                    if (gnt_rnd_s || gnt_cpu_s) begin
                        state_q     <= ST_ACCESS;
                        cnt_q       <= CNT_INIT;
                        owner_cpu_q <= gnt_cpu_s;
                        vram_en_q   <= 1'b1;
                        vram_we_q   <= gnt_cpu_s && buf_we_q;
                        vram_addr_q <= gnt_cpu_s ? buf_addr_q : rnd_addr_i;
                        if (gnt_cpu_s) begin
                            vram_wdata_q <= buf_wdata_q;
                        end else begin
                            vram_wdata_q <= vram_wdata_q;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q == 3'd0) begin
                        state_q   <= ST_RESP;
                        vram_en_q <= 1'b0;
                        vram_we_q <= 1'b0;
                        if (owner_cpu_q) begin
                            cpu_done_q <= 1'b1;
                            if (!buf_we_q) begin
                                cpu_rdata_q <= vram_rdata_i;
                            end else begin
                                cpu_rdata_q <= cpu_rdata_q;
                            end
                        end else begin
                            rnd_rvalid_q <= 1'b1;
                            rnd_rdata_q  <= vram_rdata_i;
                        end
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    vram_en_q <= 1'b0;
                    vram_we_q <= 1'b0;
                end
            endcase
        end
    end

    // CPU buffer: capture when empty, free as the access responds, flag overruns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= 1'b0;
            buf_we_q    <= 1'b0;
            buf_addr_q  <= {AW{1'b0}};
            buf_wdata_q <= {DW{1'b0}};
            overrun_q   <= 1'b0;
        end else begin
            if (cpu_req_i && !busy_q) begin
                busy_q      <= 1'b1;
                buf_we_q    <= cpu_we_i;
                buf_addr_q  <= cpu_addr_i;
                buf_wdata_q <= cpu_wdata_i;
            end else if (cpu_fin_s) begin
                busy_q <= 1'b0;
            end else begin
                busy_q <= busy_q;
            end
            if (cpu_req_i && busy_q) begin
                overrun_q <= 1'b1;
            end else if (cpu_overrun_clr_i) begin
                overrun_q <= 1'b0;
            end else begin
                overrun_q <= overrun_q;
            end
        end
    end

    assign rnd_gnt_o     = rst_n && gnt_rnd_s;
    assign rnd_rvalid_o  = rnd_rvalid_q;
    assign rnd_rdata_o   = rnd_rdata_q;
    assign cpu_busy_o    = busy_q;
    assign cpu_done_o    = cpu_done_q;
    assign cpu_rdata_o   = cpu_rdata_q;
    assign cpu_overrun_o = overrun_q;
    assign vram_en_o     = vram_en_q;
    assign vram_we_o     = vram_we_q;
    assign vram_addr_o   = vram_addr_q;
    assign vram_wdata_o  = vram_wdata_q;

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Bench for ppu_vram_arbiter: transaction-timeline model checked every clock plus
// directed scenarios with hand-computed literal expectations.
module tb_ppu_vram_arbiter;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rendering_active = 1'b0;
    logic        rnd_req = 1'b0;
    logic [13:0] rnd_addr = 14'h0;
    logic        rnd_gnt, rnd_rvalid;
    logic [7:0]  rnd_rdata;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [13:0] cpu_addr = 14'h0;
    logic [7:0]  cpu_wdata = 8'h0;
    logic        cpu_busy, cpu_done, cpu_overrun;
    logic [7:0]  cpu_rdata;
    logic        cpu_overrun_clr = 1'b0;
    logic        vram_en, vram_we;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wdata, vram_rdata;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int rv_cnt = 0;

    ppu_vram_arbiter #(.AW(14), .DW(8), .MEM_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n), .rendering_active_i(rendering_active),
        .rnd_req_i(rnd_req), .rnd_addr_i(rnd_addr), .rnd_gnt_o(rnd_gnt),
        .rnd_rvalid_o(rnd_rvalid), .rnd_rdata_o(rnd_rdata),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_wdata_i(cpu_wdata), .cpu_busy_o(cpu_busy), .cpu_done_o(cpu_done),
        .cpu_rdata_o(cpu_rdata), .cpu_overrun_o(cpu_overrun),
        .cpu_overrun_clr_i(cpu_overrun_clr), .vram_en_o(vram_en), .vram_we_o(vram_we),
        .vram_addr_o(vram_addr), .vram_wdata_o(vram_wdata), .vram_rdata_i(vram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [13:0] a);
        if (a == 14'h23C0) return 8'h5A;
        return a[7:0] ^ {2'b00, a[13:8]} ^ 8'hA5;
    endfunction

    assign vram_rdata = rom(vram_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rnd_rvalid === 1'b1) rv_cnt <= rv_cnt + 1;

    // Transaction-level model: an access granted at cycle s owns the port s+1..s+L, responds at s+L+1
    bit          m_busy, m_bwe, m_act, m_own_cpu, m_awe, m_ov;
    logic [13:0] m_baddr, m_aaddr, m_vaddr;
    logic [7:0]  m_bwd, m_vwd, m_rrd, m_crd;
    int          m_start;

    always @(negedge clk) begin
        bit in_acc, is_resp, e_rv, e_done, g_r, g_c;
        if (!rst_n) begin
            m_busy = 0; m_bwe = 0; m_act = 0; m_own_cpu = 0; m_awe = 0; m_ov = 0;
            m_baddr = '0; m_aaddr = '0; m_vaddr = '0; m_bwd = '0; m_vwd = '0;
            m_rrd = '0; m_crd = '0; m_start = 0;
            g_r = 0; g_c = 0; e_rv = 0; e_done = 0; in_acc = 0;
        end else begin
            in_acc  = m_act && (cyc > m_start) && (cyc <= m_start + L);
            is_resp = m_act && (cyc == m_start + L + 1);
            e_rv    = is_resp && !m_own_cpu;
            e_done  = is_resp && m_own_cpu;
            if (e_rv) m_rrd = rom(m_aaddr);
            if (e_done) begin
                if (!m_awe) m_crd = rom(m_aaddr);
                m_busy = 0;
            end
            if (is_resp) m_act = 0;
            g_r = !in_acc && rnd_req;
            g_c = !in_acc && !rnd_req && m_busy && !rendering_active;
        end
        chk("m_rnd_gnt", rnd_gnt, g_r);
        chk("m_rnd_rvalid", rnd_rvalid, e_rv);
        chk("m_rnd_rdata", rnd_rdata, m_rrd);
        chk("m_cpu_done", cpu_done, e_done);
        chk("m_cpu_rdata", cpu_rdata, m_crd);
        chk("m_cpu_busy", cpu_busy, m_busy);
        chk("m_cpu_overrun", cpu_overrun, m_ov);
        chk("m_vram_en", vram_en, in_acc);
        chk("m_vram_we", vram_we, in_acc && m_own_cpu && m_awe);
        chk("m_vram_addr", vram_addr, m_vaddr);
        chk("m_vram_wdata", vram_wdata, m_vwd);
        if (rst_n) begin
            if (g_r || g_c) begin
                m_act = 1; m_start = cyc; m_own_cpu = g_c;
                m_aaddr = g_c ? m_baddr : rnd_addr;
                m_awe = g_c && m_bwe;
                m_vaddr = m_aaddr;
                if (g_c) m_vwd = m_bwd;
            end
            if (cpu_req && m_busy) m_ov = 1;
            else if (cpu_overrun_clr) m_ov = 0;
            if (cpu_req && !m_busy) begin
                m_busy = 1; m_bwe = cpu_we; m_baddr = cpu_addr; m_bwd = cpu_wdata;
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        int rv_base;
        // Reset state
        nxt(); smp(); nxt(); smp();
        chk("rst_busy", cpu_busy, 1'b0);
        chk("rst_vram_en", vram_en, 1'b0);
        nxt(); rst_n = 1'b1; smp();

        // Render read at 0x23C0
        nxt(); rnd_req = 1'b1; rnd_addr = 14'h23C0; smp();
        chk("t2_gnt", rnd_gnt, 1'b1);
        nxt(); rnd_req = 1'b0; smp();
        chk("t2_en1", vram_en, 1'b1);
        chk("t2_addr", vram_addr, 14'h23C0);
        nxt(); smp();
        chk("t2_en2", vram_en, 1'b1);
        nxt(); smp();
        chk("t2_rvalid", rnd_rvalid, 1'b1);
        chk("t2_rdata", rnd_rdata, 8'h5A);
        chk("t2_en_off", vram_en, 1'b0);

        // CPU write 0x0F to 0x3F00
        nxt(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h3F00; cpu_wdata = 8'h0F; smp();
        chk("t3_busy0", cpu_busy, 1'b0);
        nxt(); cpu_req = 1'b0; smp();
        chk("t3_busy1", cpu_busy, 1'b1);
        nxt(); smp();
        chk("t3_we1", vram_we, 1'b1);
        chk("t3_addr", vram_addr, 14'h3F00);
        chk("t3_wdata", vram_wdata, 8'h0F);
        nxt(); smp();
        chk("t3_we2", vram_we, 1'b1);
        nxt(); smp();
        chk("t3_done", cpu_done, 1'b1);
        chk("t3_busy_free", cpu_busy, 1'b0);

        // Render and buffered CPU read pending together
        nxt(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h2000; smp();
        nxt(); cpu_req = 1'b0; rnd_req = 1'b1; rnd_addr = 14'h0155; smp();
        chk("t4_gnt", rnd_gnt, 1'b1);
        nxt(); rnd_req = 1'b0; smp();
        nxt(); smp();
        nxt(); smp();
        chk("t4_rvalid", rnd_rvalid, 1'b1);
        chk("t4_rdata", rnd_rdata, 8'hF1);
        nxt(); smp();
        chk("t4_cpu_addr", vram_addr, 14'h2000);
        nxt(); smp();
        nxt(); smp();
        chk("t4_done", cpu_done, 1'b1);
        chk("t4_cpu_rdata", cpu_rdata, 8'h85);

        // CPU starved while rendering, overrun, then served
        nxt(); rendering_active = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1;
        cpu_addr = 14'h3F01; cpu_wdata = 8'h11; smp();
        nxt(); cpu_req = 1'b0; smp();
        chk("t5_busy", cpu_busy, 1'b1);
        nxt(); cpu_req = 1'b1; cpu_addr = 14'h0000; cpu_wdata = 8'hEE; smp();
        nxt(); cpu_req = 1'b0; smp();
        chk("t5_ov", cpu_overrun, 1'b1);
        nxt(); cpu_req = 1'b1; cpu_overrun_clr = 1'b1; smp();
        nxt(); cpu_req = 1'b0; cpu_overrun_clr = 1'b0; smp();
        chk("t5_ov_setwins", cpu_overrun, 1'b1);
        chk("t5_starved", vram_en, 1'b0);
        nxt(); rendering_active = 1'b0; smp();
        nxt(); smp();
        chk("t5_we", vram_we, 1'b1);
        chk("t5_addr", vram_addr, 14'h3F01);
        chk("t5_wdata", vram_wdata, 8'h11);
        nxt(); smp();
        nxt(); smp();
        chk("t5_done", cpu_done, 1'b1);
        nxt(); cpu_overrun_clr = 1'b1; smp();
        chk("t5_ov_hold", cpu_overrun, 1'b1);
        nxt(); cpu_overrun_clr = 1'b0; smp();
        chk("t5_ov_clr", cpu_overrun, 1'b0);

        // 340 back-to-back fetches
        nxt(); rv_base = rv_cnt; rnd_req = 1'b1; rnd_addr = 14'h0100;
        for (int k = 0; k < 340; k++) begin
            smp();
            chk("t6_gnt", rnd_gnt, 1'b1);
            nxt();
            if (k == 339) rnd_req = 1'b0;
            else rnd_addr = 14'h0100 + 14'(k + 1);
            nxt();
            nxt();
        end
        smp(); #1;
        chk("t6_rvalid_cnt", rv_cnt - rv_base, 340);

        // Reset mid-access
        nxt(); rnd_req = 1'b1; rnd_addr = 14'h1234; smp();
        chk("t1_gnt", rnd_gnt, 1'b1);
        nxt(); rnd_req = 1'b0; smp();
        chk("t1_en", vram_en, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("t1_en_rst", vram_en, 1'b0);
        chk("t1_addr_rst", vram_addr, 14'h0);
        rnd_req = 1'b1; rnd_addr = 14'h0ABC;
        #1;
        chk("t1_gnt_rst", rnd_gnt, 1'b0);
        nxt(); smp();
        nxt(); rst_n = 1'b1; smp();
        chk("t1_gnt_after", rnd_gnt, 1'b1);
        nxt(); rnd_req = 1'b0;
        nxt();
        nxt(); smp();
        chk("t1_rvalid", rnd_rvalid, 1'b1);
        chk("t1_rdata", rnd_rdata, 8'h13);

        nxt(); smp();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
